sdc_ctrl: RTL and testbench

- Top-level sequencer for the SD-card SPI path.
- Starts the init engine after reset and supervises it with timeout and retry.
- Once the card is ready, accepts single-block read requests from a host and dispatches them to the block-read engine.
- Owns the shared SPI pins and muxes MOSI/CS/SCK-enable from whichever engine currently holds the bus.

---
 rtl/sdc_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_sdc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_ctrl.sv
// Top-level SD-card SPI sequencer: supervises the init engine (timeout/retry),
// dispatches single-block reads and muxes the shared SPI pins to the bus owner.
module sdc_ctrl #(
    parameter int unsigned INIT_TIMEOUT = 50000,
    parameter int unsigned RD_TIMEOUT   = 10000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned GAP_CYCLES   = 100
) (
    input  logic        w_clk_100_KHz,
    input  logic        w_rst,
    output logic        o_init_start,
    input  logic        i_init_done,
    input  logic        i_init_mosi,
    input  logic        i_init_cs,
    input  logic        i_init_sck_en,
    output logic        o_rd_start,
    output logic [31:0] o_rd_addr,
    input  logic        i_rd_done,
    input  logic        i_rd_err,
    input  logic        i_rd_mosi,
    input  logic        i_rd_cs,
    input  logic        i_rd_sck_en,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_reinit,
    output logic        o_ack,
    output logic        o_rd_valid,
    output logic        o_rd_fail,
    output logic        o_ready,
    output logic        o_fatal,
    output logic        o_mosi,
    output logic        o_cs,
    output logic        o_sck_en
);

    localparam int unsigned MAX_A   = (INIT_TIMEOUT > RD_TIMEOUT) ? INIT_TIMEOUT : RD_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned ADDR_W  = 32;

    localparam logic [CNT_W-1:0]   INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   RD_LAST   = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        INIT_START,
        INIT_WAIT,
        GAP,
        READY,
        RD_START,
        RD_WAIT,
        FAIL
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [RETRY_W-1:0]  retry_q,      retry_d;
    logic [ADDR_W-1:0]   rd_addr_q,    rd_addr_d;
    logic                init_start_q, init_start_d;
    logic                rd_start_q,   rd_start_d;
    logic                ack_q,        ack_d;
    logic                rd_valid_q,   rd_valid_d;
    logic                rd_fail_q,    rd_fail_d;
    logic                ready_q,      ready_d;
    logic                fatal_q,      fatal_d;
    logic                mosi_q,       mosi_d;
    logic                cs_q,         cs_d;
    logic                sck_en_q,     sck_en_d;

    // Next-state, counters and registered-output values
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        rd_addr_d  = rd_addr_q;
        ack_d      = 1'b0;
        rd_valid_d = 1'b0;
        rd_fail_d  = 1'b0;

        case (state_q)
            IDLE:       state_d = INIT_START;
            INIT_START: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (i_init_done) begin
                    retry_d = '0;
                    state_d = READY;
                end else if (cnt_q == INIT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = GAP;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) state_d = INIT_START;
            end
            READY: begin
                if (i_reinit) begin
                    retry_d = '0;
                    state_d = INIT_START;
                end else if (i_req) begin
                    rd_addr_d = i_addr;
                    ack_d     = 1'b1;
                    state_d   = RD_START;
                end
            end
            RD_START:   state_d = RD_WAIT;
            RD_WAIT: begin
                if (i_rd_done) begin
                    rd_valid_d = !i_rd_err;
                    rd_fail_d  = i_rd_err;
                    state_d    = READY;
                end else if (cnt_q == RD_LAST) begin
                    rd_fail_d = 1'b1;
                    state_d   = FAIL;
                end
            end
            FAIL: begin
                if (i_reinit) begin
                    retry_d = '0;
                    state_d = INIT_START;
                end
            end
            default:    state_d = IDLE;
        endcase

        // Counter restarts on every state change and saturates otherwise
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        init_start_d = (state_d == INIT_START);
        rd_start_d   = (state_d == RD_START);
        ready_d      = (state_d == READY);
        fatal_d      = (state_d == FAIL);

        // Pins follow the owner of the state being entered, so they change with the state
        case (state_d)
            INIT_START, INIT_WAIT: begin
                mosi_d   = i_init_mosi;
                cs_d     = i_init_cs;
                sck_en_d = i_init_sck_en;
            end
            RD_START, RD_WAIT: begin
                mosi_d   = i_rd_mosi;
                cs_d     = i_rd_cs;
                sck_en_d = i_rd_sck_en;
            end
            default: begin
                mosi_d   = 1'b1;
                cs_d     = 1'b1;
                sck_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge w_clk_100_KHz or posedge w_rst) begin
        if (w_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            rd_addr_q    <= '0;
            init_start_q <= 1'b0;
            rd_start_q   <= 1'b0;
            ack_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_fail_q    <= 1'b0;
            ready_q      <= 1'b0;
            fatal_q      <= 1'b0;
            mosi_q       <= 1'b1;
            cs_q         <= 1'b1;
            sck_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            rd_addr_q    <= rd_addr_d;
            init_start_q <= init_start_d;
            rd_start_q   <= rd_start_d;
            ack_q        <= ack_d;
            rd_valid_q   <= rd_valid_d;
            rd_fail_q    <= rd_fail_d;
            ready_q      <= ready_d;
            fatal_q      <= fatal_d;
            mosi_q       <= mosi_d;
            cs_q         <= cs_d;
            sck_en_q     <= sck_en_d;
        end
    end

    assign o_init_start = init_start_q;
    assign o_rd_start   = rd_start_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_ack        = ack_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_fail    = rd_fail_q;
    assign o_ready      = ready_q;
    assign o_fatal      = fatal_q;
    assign o_mosi       = mosi_q;
    assign o_cs         = cs_q;
    assign o_sck_en     = sck_en_q;

endmodule

// File: tb/tb_sdc_ctrl.sv
// Directed bench for sdc_ctrl with short timeouts so every path fits in a few
// thousand cycles; engine pin levels differ per owner so the pin mux is observable.
`timescale 1ns/1ps
module tb_sdc_ctrl;

    localparam int unsigned INIT_TO = 50;
    localparam int unsigned RD_TO   = 40;
    localparam int unsigned RETRIES = 3;
    localparam int unsigned GAP     = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_init_start, i_init_done, i_init_mosi, i_init_cs, i_init_sck_en;
    logic        o_rd_start;
    logic [31:0] o_rd_addr;
    logic        i_rd_done, i_rd_err, i_rd_mosi, i_rd_cs, i_rd_sck_en;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_reinit;
    logic        o_ack, o_rd_valid, o_rd_fail, o_ready, o_fatal;
    logic        o_mosi, o_cs, o_sck_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdc_ctrl #(
        .INIT_TIMEOUT (INIT_TO),
        .RD_TIMEOUT   (RD_TO),
        .MAX_RETRY    (RETRIES),
        .GAP_CYCLES   (GAP)
    ) dut (
        .w_clk_100_KHz (clk),
        .w_rst         (rst),
        .o_init_start  (o_init_start),
        .i_init_done   (i_init_done),
        .i_init_mosi   (i_init_mosi),
        .i_init_cs     (i_init_cs),
        .i_init_sck_en (i_init_sck_en),
        .o_rd_start    (o_rd_start),
        .o_rd_addr     (o_rd_addr),
        .i_rd_done     (i_rd_done),
        .i_rd_err      (i_rd_err),
        .i_rd_mosi     (i_rd_mosi),
        .i_rd_cs       (i_rd_cs),
        .i_rd_sck_en   (i_rd_sck_en),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_reinit      (i_reinit),
        .o_ack         (o_ack),
        .o_rd_valid    (o_rd_valid),
        .o_rd_fail     (o_rd_fail),
        .o_ready       (o_ready),
        .o_fatal       (o_fatal),
        .o_mosi        (o_mosi),
        .o_cs          (o_cs),
        .o_sck_en      (o_sck_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after an o_init_start pulse with i_init_done held low
    task automatic run_timeouts();
        int pulses;
        for (int k = 0; k <= int'(RETRIES); k++) begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
                if (n == 25) chk("iw_cs_mirror", 32'(o_cs), 32'd0);
                if (n == 51) begin
                    chk("gap_cs", 32'(o_cs), 32'd1);
                    chk("gap_sck_en", 32'(o_sck_en), 32'd0);
                end
            end while (!o_init_start && !o_fatal && n < 200);
            if (k < int'(RETRIES)) begin
                chk("retry_spacing", 32'(n), 32'd61);
                chk("retry_pulse", 32'(o_init_start), 32'd1);
            end else begin
                chk("fatal_latency", 32'(n), 32'd51);
                chk("fatal_set", 32'(o_fatal), 32'd1);
                chk("fatal_ready", 32'(o_ready), 32'd0);
                chk("fatal_cs", 32'(o_cs), 32'd1);
            end
        end
        pulses = 0;
        repeat (20) begin
            tick();
            if (o_init_start) pulses++;
        end
        chk("no_start_in_fail", 32'(pulses), 32'd0);
    endtask

    task automatic request(input logic [31:0] a);
        i_req  = 1'b1;
        i_addr = a;
        tick();
        i_req  = 1'b0;
        chk("req_ack", 32'(o_ack), 32'd1);
        chk("req_rd_start", 32'(o_rd_start), 32'd1);
        chk("req_addr", o_rd_addr, a);
        chk("req_ready_drop", 32'(o_ready), 32'd0);
    endtask

    task automatic finish_init(input int unsigned delay);
        repeat (delay) tick();
        i_init_done = 1'b1;
        tick();
        i_init_done = 1'b0;
        chk("init_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        i_init_done   = 1'b0;
        i_init_mosi   = 1'b1;
        i_init_cs     = 1'b0;
        i_init_sck_en = 1'b1;
        i_rd_done     = 1'b0;
        i_rd_err      = 1'b0;
        i_rd_mosi     = 1'b0;
        i_rd_cs       = 1'b0;
        i_rd_sck_en   = 1'b1;
        i_req         = 1'b0;
        i_addr        = '0;
        i_reinit      = 1'b0;

        repeat (3) tick();
        chk("rst_cs", 32'(o_cs), 32'd1);
        chk("rst_mosi", 32'(o_mosi), 32'd1);
        chk("rst_sck_en", 32'(o_sck_en), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_fatal", 32'(o_fatal), 32'd0);
        chk("rst_addr", o_rd_addr, 32'd0);
        chk("rst_init_start", 32'(o_init_start), 32'd0);
        chk("rst_ack", 32'(o_ack), 32'd0);

        rst = 1'b0;
        tick();
        chk("start_after_rst", 32'(o_init_start), 32'd1);
        chk("start_pins_cs", 32'(o_cs), 32'd0);

        // Init never completes: 4 attempts then fatal
        run_timeouts();

        // Re-init from FAIL must restart the retry budget (4 attempts again)
        i_reinit = 1'b1;
        tick();
        i_reinit = 1'b0;
        chk("reinit_start", 32'(o_init_start), 32'd1);
        chk("reinit_fatal_clr", 32'(o_fatal), 32'd0);
        run_timeouts();

        // Successful init with pin mirroring
        i_reinit = 1'b1;
        tick();
        i_reinit = 1'b0;
        chk("init2_start", 32'(o_init_start), 32'd1);
        tick();
        chk("start_single", 32'(o_init_start), 32'd0);
        chk("iw_mosi_hi", 32'(o_mosi), 32'd1);
        i_init_mosi = 1'b0;
        tick();
        chk("iw_mosi_lo", 32'(o_mosi), 32'd0);
        i_init_mosi = 1'b1;
        tick();
        chk("iw_mosi_back", 32'(o_mosi), 32'd1);
        finish_init(17);
        chk("ready_cs_idle", 32'(o_cs), 32'd1);
        chk("ready_sck_idle", 32'(o_sck_en), 32'd0);
        chk("ready_fatal", 32'(o_fatal), 32'd0);

        // Stray done strobes outside their wait states
        i_init_done = 1'b1;
        i_rd_done   = 1'b1;
        tick();
        i_init_done = 1'b0;
        i_rd_done   = 1'b0;
        chk("stray_ready", 32'(o_ready), 32'd1);
        chk("stray_valid", 32'(o_rd_valid), 32'd0);
        chk("stray_start", 32'(o_init_start), 32'd0);

        // Good read
        request(32'h0000_1234);
        tick();
        chk("rw_rd_start_single", 32'(o_rd_start), 32'd0);
        chk("rw_ack_single", 32'(o_ack), 32'd0);
        chk("rw_cs_owner", 32'(o_cs), 32'd0);
        chk("rw_mosi_owner", 32'(o_mosi), 32'd0);
        repeat (23) tick();
        i_rd_done = 1'b1;
        tick();
        i_rd_done = 1'b0;
        chk("ok_valid", 32'(o_rd_valid), 32'd1);
        chk("ok_fail", 32'(o_rd_fail), 32'd0);
        chk("ok_ready", 32'(o_ready), 32'd1);
        chk("ok_addr_hold", o_rd_addr, 32'h0000_1234);
        chk("ok_cs_idle", 32'(o_cs), 32'd1);
        tick();
        chk("ok_valid_pulse", 32'(o_rd_valid), 32'd0);

        // Read with token/CRC error
        request(32'hDEAD_BEEF);
        repeat (10) tick();
        i_rd_done = 1'b1;
        i_rd_err  = 1'b1;
        tick();
        i_rd_done = 1'b0;
        i_rd_err  = 1'b0;
        chk("err_fail", 32'(o_rd_fail), 32'd1);
        chk("err_valid", 32'(o_rd_valid), 32'd0);
        chk("err_fatal", 32'(o_fatal), 32'd0);
        chk("err_ready", 32'(o_ready), 32'd1);

        // Silent read engine: RD_WAIT lasts RD_TO cycles, then fail + fatal
        request(32'h0000_0042);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_rd_fail && n < 200);
        chk("rto_latency", 32'(n), 32'd41);
        chk("rto_fatal", 32'(o_fatal), 32'd1);
        chk("rto_ready", 32'(o_ready), 32'd0);
        chk("rto_cs_idle", 32'(o_cs), 32'd1);
        i_req  = 1'b1;
        i_addr = 32'h0000_0099;
        tick();
        i_req  = 1'b0;
        chk("fail_req_ignored", 32'(o_ack), 32'd0);
        chk("fail_addr_hold", o_rd_addr, 32'h0000_0042);
        i_reinit = 1'b1;
        tick();
        i_reinit = 1'b0;
        chk("rto_reinit_start", 32'(o_init_start), 32'd1);
        chk("rto_reinit_fatal", 32'(o_fatal), 32'd0);
        finish_init(5);

        // Re-init beats a simultaneous request
        i_reinit = 1'b1;
        i_req    = 1'b1;
        i_addr   = 32'h0000_0077;
        tick();
        i_reinit = 1'b0;
        i_req    = 1'b0;
        chk("prio_start", 32'(o_init_start), 32'd1);
        chk("prio_no_ack", 32'(o_ack), 32'd0);
        chk("prio_ready", 32'(o_ready), 32'd0);
        chk("prio_addr", o_rd_addr, 32'h0000_0042);
        finish_init(5);

        // Asynchronous reset while a read is in flight
        request(32'h0000_5555);
        repeat (5) tick();
        chk("pre_rst_cs", 32'(o_cs), 32'd0);
        rst = 1'b1;
        #2;
        chk("arst_cs", 32'(o_cs), 32'd1);
        chk("arst_mosi", 32'(o_mosi), 32'd1);
        chk("arst_sck_en", 32'(o_sck_en), 32'd0);
        chk("arst_addr", o_rd_addr, 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd0);
        chk("arst_fatal", 32'(o_fatal), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_start", 32'(o_init_start), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
